// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and BCD validity helper for the 2-digit BCD adder path
package bcd_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      SHOW   = 2'b10
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd8(input logic [7:0] v);
      return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_operand_entry_key_conditioner.sv
// rtl/bcd_operand_entry_key_conditioner.sv - pushbutton synchroniser, optional debounce (DEBOUNCE_EN), press pulse
module key_conditioner
`ifdef DEBOUNCE_EN
#(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned DEB_W      = 19
)
`endif
(
   input  logic Clock,
   input  logic Resetn,
   input  logic key_n,
   output logic press
);

   logic       sync1_q, sync2_q;
   logic [1:0] flush_q;
   logic       armed_q;
   logic       press_q;

   // A key already low when reset releases must go high once before it can press.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         flush_q <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         flush_q <= {flush_q[0], 1'b1};
         armed_q <= armed_q | (flush_q[1] & sync2_q);
      end
   end

`ifdef DEBOUNCE_EN
   logic [DEB_W-1:0] cnt_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         if (sync2_q)
            cnt_q <= '0;
         else if (cnt_q != DEB_W'(DEB_CYCLES))
            cnt_q <= cnt_q + 1'b1;
         press_q <= armed_q & ~sync2_q & (cnt_q == DEB_W'(DEB_CYCLES - 1));
      end
   end
`else
   logic prev_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         prev_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         prev_q  <= sync2_q;
         press_q <= armed_q & prev_q & ~sync2_q;
      end
   end
`endif

   assign press = press_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - two-press BCD operand capture FSM; DEBOUNCE_EN enables key debounce
module bcd_operand_entry
   import bcd_pkg::*;
`ifdef DEBOUNCE_EN
#(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned DEB_W      = 19
)
`endif
(
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [7:0] SW_in,
   input  logic       key_n,
   output logic [7:0] A_out,
   output logic [7:0] B_out,
   output logic       valid,
   output logic       err,
   output logic [1:0] state_led
);

   logic       press;
   state_e     state_q;
   logic [7:0] a_q, b_q;
   logic       valid_q, err_q;

`ifdef DEBOUNCE_EN
   key_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_key (
`else
   key_conditioner u_key (
`endif
      .Clock  (Clock),
      .Resetn (Resetn),
      .key_n  (key_n),
      .press  (press)
   );

   // SW_in is sampled unsynchronised: the user holds it steady well before pressing.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= LOAD_A;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: if (press) begin
               if (is_bcd8(SW_in)) begin
                  a_q     <= SW_in;
                  err_q   <= 1'b0;
                  state_q <= LOAD_B;
               end else begin
                  err_q   <= 1'b1;
               end
            end
            LOAD_B: if (press) begin
               if (is_bcd8(SW_in)) begin
                  b_q     <= SW_in;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= SHOW;
               end else begin
                  err_q   <= 1'b1;
               end
            end
            SHOW: if (press) begin
               a_q     <= 8'h00;
               b_q     <= 8'h00;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= LOAD_A;
            end
            default: begin
               a_q     <= 8'h00;
               b_q     <= 8'h00;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= LOAD_A;
            end
         endcase
      end
   end

   assign A_out     = a_q;
   assign B_out     = b_q;
   assign valid     = valid_q;
   assign err       = err_q;
   assign state_led = state_q;

endmodule
